if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 15 +
 rtl/if_skid_buf.sv | 39 +++
 rtl/if_stage.sv | 133 +++++++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and FSM state type for the instruction fetch front end.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        BUF   = 2'd2,
        KILL  = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding slot for a fetched instruction that arrived while ID was stalled.
module if_skid_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic [XLEN-1:0] buf_pc,
    output logic [XLEN-1:0] buf_instr,
    output logic            buf_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
        end else if (unload) begin
            buf_valid <= 1'b0;
        end
    end

    // Payload only matters while buf_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            buf_pc    <= load_pc;
            buf_instr <= load_instr;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single outstanding request, stall skid slot, jump redirect with kill.
module if_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            jump_flag,
    input  logic [XLEN-1:0] jump_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_valid
);

    import riscv_pkg::*;

    localparam logic [XLEN-1:0] NOP        = XLEN'(NOP_INSTR);
    localparam logic [XLEN-1:0] WORD_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    if_state_e       state;
    logic [XLEN-1:0] saved_target;
    logic [XLEN-1:0] jump_addr;

    logic            buf_load;
    logic            buf_unload;
    logic            buf_clear;
    logic [XLEN-1:0] buf_pc;
    logic [XLEN-1:0] buf_instr;
    logic            buf_valid;

    assign jump_addr = jump_target & ALIGN_MASK;

    // Skid slot control; ack feeds only the slot, never the request path.
    always_comb begin
        buf_clear  = jump_flag;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        if (!jump_flag) begin
            buf_load   = (state == FETCH) && imem_ack && stall;
            buf_unload = (state == BUF) && !stall;
        end
    end

    if_skid_buf #(
        .XLEN(XLEN)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .unload    (buf_unload),
        .clear     (buf_clear),
        .load_pc   (imem_addr),
        .load_instr(imem_rdata),
        .buf_pc    (buf_pc),
        .buf_instr (buf_instr),
        .buf_valid (buf_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            if_pc        <= RESET_PC;
            if_instr     <= NOP;
            if_valid     <= 1'b0;
            saved_target <= '0;
        end else if (jump_flag) begin
            if_valid <= 1'b0;
            if_instr <= NOP;
            // A request still in flight must drain before the target can be issued.
            if (state == BOOT || state == BUF || imem_ack) begin
                imem_addr <= jump_addr;
                imem_req  <= 1'b1;
                state     <= FETCH;
            end else begin
                saved_target <= jump_addr;
                state        <= KILL;
            end
        end else begin
            case (state)
                BOOT: begin
                    imem_addr <= RESET_PC;
                    imem_req  <= 1'b1;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (!stall) begin
                            if_pc     <= imem_addr;
                            if_instr  <= imem_rdata;
                            if_valid  <= 1'b1;
                            imem_addr <= imem_addr + WORD_STEP;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= BUF;
                        end
                    end else if (!stall) begin
                        // ID consumed the presented instruction and nothing new arrived.
                        if_valid <= 1'b0;
                    end
                end
                BUF: begin
                    if (!stall) begin
                        if_pc     <= buf_pc;
                        if_instr  <= buf_instr;
                        if_valid  <= buf_valid;
                        imem_addr <= buf_pc + WORD_STEP;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                    end
                end
                KILL: begin
                    if (imem_ack) begin
                        imem_addr <= saved_target;
                        state     <= FETCH;
                    end
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table on a 1-cycle memory plus multi-cycle corner sequences.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    int   lat       = 1;
    int   cnt;
    logic force_ack = 1'b0;
    int   n_checks  = 0;
    int   n_pass    = 0;

    typedef struct {
        logic        stall;
        logic        jump;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } vec_t;

    vec_t vecs [17];

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .jump_flag  (jump_flag),
        .jump_target(jump_target),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_valid   (if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00A0_0093;
            32'h0000_0004: return 32'h0010_0113;
            32'h0000_0008: return 32'hDEAD_BEEF;
            default:       return {a[15:0], 16'h0013};
        endcase
    endfunction

    // Memory model: acks on the lat-th cycle a request is presented.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cnt <= 0;
        else if (!imem_req || imem_ack) cnt <= 0;
        else                           cnt <= cnt + 1;
    end

    assign imem_ack   = force_ack | (imem_req && (cnt == lat - 1));
    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           stall jump tgt           req   addr          pc            instr         valid
        vecs[0]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0000_0000, 32'h0000_0000, NOP,          1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0000, 32'h0000_0000, NOP,          1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0004, 32'h0000_0000, 32'h00A00093, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0008, 32'h0000_0004, 32'h00100113, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_0008, 32'h0000_0004, 32'h00100113, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_0008, 32'h0000_0004, 32'h00100113, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0000_0008, 32'h0000_0004, 32'h00100113, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_000C, 32'h0000_0008, 32'hDEADBEEF, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 32'h203,     1'b1, 32'h0000_0010, 32'h0000_000C, 32'h000C0013, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0200, 32'h0000_000C, NOP,          1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0000_0200, 32'h0000_000C, NOP,          1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h40,      1'b1, 32'h0000_0204, 32'h0000_0200, 32'h02000013, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0040, 32'h0000_0200, NOP,          1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_0044, 32'h0000_0040, 32'h00400013, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 32'h80,      1'b0, 32'h0000_0044, 32'h0000_0040, 32'h00400013, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0080, 32'h0000_0040, NOP,          1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0084, 32'h0000_0080, 32'h00800013, 1'b1};

        rst_n       = 1'b0;
        stall       = 1'b0;
        jump_flag   = 1'b0;
        jump_target = 32'h0;
        repeat (2) @(negedge clk);
        check("rst.req",   {31'b0, imem_req}, 32'h0);
        check("rst.addr",  imem_addr, 32'h0);
        check("rst.pc",    if_pc, 32'h0);
        check("rst.instr", if_instr, NOP);
        check("rst.valid", {31'b0, if_valid}, 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check($sformatf("vec%0d.req", i),   {31'b0, imem_req}, {31'b0, vecs[i].req});
            check($sformatf("vec%0d.addr", i),  imem_addr, vecs[i].addr);
            check($sformatf("vec%0d.pc", i),    if_pc, vecs[i].pc);
            check($sformatf("vec%0d.instr", i), if_instr, vecs[i].instr);
            check($sformatf("vec%0d.valid", i), {31'b0, if_valid}, {31'b0, vecs[i].valid});
            stall       = vecs[i].stall;
            jump_flag   = vecs[i].jump;
            jump_target = vecs[i].tgt;
            @(negedge clk);
        end
        stall     = 1'b0;
        jump_flag = 1'b0;

        // Address wrap at the top of the space.
        jump_flag   = 1'b1;
        jump_target = 32'hFFFF_FFFF;
        @(negedge clk);
        jump_flag = 1'b0;
        check("wrap.addr_top", imem_addr, 32'hFFFF_FFFC);
        check("wrap.valid0",   {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        check("wrap.addr_next", imem_addr, 32'h0000_0000);
        check("wrap.pc",        if_pc, 32'hFFFF_FFFC);
        check("wrap.instr",     if_instr, 32'hFFFC_0013);
        check("wrap.valid1",    {31'b0, if_valid}, 32'h1);

        // Three-cycle memory: redirect while the 0x20 request is in flight.
        rst_n = 1'b0;
        lat   = 3;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100 && imem_addr != 32'h20; k++) @(negedge clk);
        check("kill.reach20", imem_addr, 32'h20);
        @(negedge clk);
        jump_flag   = 1'b1;
        jump_target = 32'h100;
        @(negedge clk);
        jump_flag = 1'b0;
        check("kill.req_held",  {31'b0, imem_req}, 32'h1);
        check("kill.addr_held", imem_addr, 32'h20);
        check("kill.valid0",    {31'b0, if_valid}, 32'h0);
        check("kill.instr_nop", if_instr, NOP);
        @(negedge clk);
        check("kill.redirect", imem_addr, 32'h100);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("kill.wait%0d.valid", k), {31'b0, if_valid}, 32'h0);
            @(negedge clk);
        end
        check("kill.deliv.valid", {31'b0, if_valid}, 32'h1);
        check("kill.deliv.pc",    if_pc, 32'h100);
        check("kill.deliv.instr", if_instr, 32'h0100_0013);
        check("kill.deliv.addr",  imem_addr, 32'h104);

        // Two jumps during one outstanding request: the later target is issued.
        jump_flag   = 1'b1;
        jump_target = 32'h300;
        @(negedge clk);
        jump_target = 32'h400;
        @(negedge clk);
        jump_flag = 1'b0;
        check("lastwins.hold", imem_addr, 32'h104);
        @(negedge clk);
        check("lastwins.addr", imem_addr, 32'h400);
        check("lastwins.req",  {31'b0, imem_req}, 32'h1);

        // Reset mid-request, then a stray ack while in BOOT.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.req",   {31'b0, imem_req}, 32'h0);
        check("arst.addr",  imem_addr, 32'h0);
        check("arst.valid", {31'b0, if_valid}, 32'h0);
        check("arst.instr", if_instr, NOP);
        @(negedge clk);
        rst_n     = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        check("lateack.req",   {31'b0, imem_req}, 32'h1);
        check("lateack.addr",  imem_addr, 32'h0);
        check("lateack.valid", {31'b0, if_valid}, 32'h0);
        repeat (3) @(negedge clk);
        check("lateack.first.valid", {31'b0, if_valid}, 32'h1);
        check("lateack.first.pc",    if_pc, 32'h0);
        check("lateack.first.instr", if_instr, 32'h00A0_0093);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
